// File: rtl/vga_timing_gen.sv
// ============================================================================
//  Module   : vga_timing_gen
//  Brief    : VGA raster timing with upstream pixel request and latency-aligned
//             sync/blank/RGB output register.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   PIX_LAT  = 2,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       enable,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_req,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    output logic [7:0] red_out,
    output logic [7:0] green_out,
    output logic [7:0] blue_out,
    output logic       hs_out,
    output logic       vs_out,
    output logic       blank_n,
    output logic       frame_start
);

    localparam int          c_H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  c_H_LAST   = 10'(c_H_TOT - 1);
    localparam logic [9:0]  c_V_LAST   = 10'(c_V_TOT - 1);
    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] c_HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] c_VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line word layout
    localparam int c_B_ACT   = 0;
    localparam int c_B_HS    = 1;
    localparam int c_B_VS    = 2;
    localparam int c_B_FIRST = 3;

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [10:0] w_h;
    logic [10:0] w_v;
    logic        w_active;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic        w_first;
    logic        w_req;
    logic [3:0]  w_stage0;
    logic [3:0]  w_dly;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (enable) begin
            if (r_h_cnt == c_H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    assign w_h      = {1'b0, r_h_cnt};
    assign w_v      = {1'b0, r_v_cnt};
    assign w_active = (w_h < c_H_ACT) && (w_v < c_V_ACT);
    assign w_hs_raw = (w_h >= c_HS_BEG) && (w_h < c_HS_END);
    assign w_vs_raw = (w_v >= c_VS_BEG) && (w_v < c_VS_END);
    assign w_first  = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
    assign w_req    = w_active & enable;

    assign pixel_req = w_req;
    assign pixel_x   = w_req ? r_h_cnt : 10'd0;
    assign pixel_y   = w_req ? r_v_cnt : 10'd0;

    // A frozen raster feeds idle words so the pipeline drains to blank
    assign w_stage0 = enable ? {w_first, w_vs_raw, w_hs_raw, w_active} : 4'd0;

    if (PIX_LAT > 0) begin : g_delay
        logic [3:0] r_dl [PIX_LAT];

        always_ff @(posedge clk_clk) begin
            if (!reset_reset_n) begin
                r_dl <= '{default: '0};
            end else begin
                r_dl[0] <= w_stage0;
                for (int i = 1; i < PIX_LAT; i++) begin
                    r_dl[i] <= r_dl[i-1];
                end
            end
        end

        assign w_dly = r_dl[PIX_LAT-1];
    end else begin : g_no_delay
        assign w_dly = w_stage0;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            red_out     <= '0;
            green_out   <= '0;
            blue_out    <= '0;
            hs_out      <= ~SYNC_POL;
            vs_out      <= ~SYNC_POL;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            red_out     <= w_dly[c_B_ACT] ? red_in   : 8'd0;
            green_out   <= w_dly[c_B_ACT] ? green_in : 8'd0;
            blue_out    <= w_dly[c_B_ACT] ? blue_in  : 8'd0;
            hs_out      <= w_dly[c_B_HS] ? SYNC_POL : ~SYNC_POL;
            vs_out      <= w_dly[c_B_VS] ? SYNC_POL : ~SYNC_POL;
            blank_n     <= w_dly[c_B_ACT];
            frame_start <= w_dly[c_B_FIRST];
        end
    end

endmodule

`default_nettype wire
